// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ writeback sources.
// Writes to $0 are accepted and counted but never reach the write decoder.
module regfile_write_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 32,
    parameter int AW   = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*AW-1:0]  req_addr,
    input  logic [NREQ*DW-1:0]  req_data,
    output logic [NREQ-1:0]     req_ready,
    input  logic                stall,
    output logic                RegWrite,
    output logic [AW-1:0]       WriteRegister,
    output logic [DW-1:0]       WriteData,
    output logic [1:0]          grant_id,
    output logic [7:0]          drop_count
);

    // Handshake: requester i's write is taken at a rising edge where req_valid[i]
    // and req_ready[i] are both high. req_ready is combinational from req_valid,
    // stall, reset and ptr; requesters hold valid/addr/data until they see ready.

    logic [1:0]    ptr;
    logic [1:0]    ptrNext;
    logic [2:0]    cand;
    logic [2:0]    ptrInc;
    logic          grantFound;
    logic [1:0]    grantIdx;
    logic [AW-1:0] addrSel;
    logic [DW-1:0] dataSel;
    logic [NREQ-1:0] readyVec;

    // Search from ptr upward, wrapping modulo NREQ; the first valid index wins.
    always_comb begin
        cand       = '0;
        grantFound = 1'b0;
        grantIdx   = '0;
        addrSel    = '0;
        dataSel    = '0;
        readyVec   = '0;
        if (!stall && !reset) begin
            for (int k = 0; k < NREQ; k++) begin
                cand = {1'b0, ptr} + 3'(k);
                if (cand >= 3'(NREQ)) begin
                    cand = cand - 3'(NREQ);
                end
                for (int j = 0; j < NREQ; j++) begin
                    if (!grantFound && cand == 3'(j) && req_valid[j]) begin
                        grantFound  = 1'b1;
                        grantIdx    = 2'(j);
                        addrSel     = req_addr[j*AW +: AW];
                        dataSel     = req_data[j*DW +: DW];
                        readyVec[j] = 1'b1;
                    end
                end
            end
        end
    end

    assign req_ready = readyVec;

    always_comb begin
        ptrInc  = {1'b0, grantIdx} + 3'd1;
        ptrNext = (ptrInc == 3'(NREQ)) ? 2'd0 : ptrInc[1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr           <= '0;
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
            grant_id      <= '0;
            drop_count    <= '0;
        end else if (grantFound) begin
            ptr      <= ptrNext;
            grant_id <= grantIdx;
            if (addrSel != '0) begin
                RegWrite      <= 1'b1;
                WriteRegister <= addrSel;
                WriteData     <= dataSel;
            end else begin
                // $0 writes are swallowed; WriteData keeps its last real value.
                RegWrite      <= 1'b0;
                WriteRegister <= '0;
                if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end
        end else begin
            RegWrite <= 1'b0;
        end
    end

endmodule
